// File: rtl/uart_core_fifo.sv
// uart_core_fifo: UART core with active-low parallel strobes, TX/RX FIFOs and sticky errors.
// Frame: start bit, DATA_WIDTH data bits LSB first, optional parity, STOP_BITS stop bits.
module uart_core_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BIT_CLKS   = 16,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  txrdy,
    input  logic                  oen,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rxrdy,
    output logic                  tx,
    input  logic                  rx,
    input  logic                  err_clr,
    output logic                  parity_err,
    output logic                  framing_err,
    output logic                  overflow
);

    localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = $clog2(BIT_CLKS);
    localparam int unsigned BitW  = $clog2(DATA_WIDTH);

    localparam logic [CntW-1:0] CntLast   = CntW'(BIT_CLKS - 1);
    localparam logic [CntW-1:0] CntHalf   = CntW'(BIT_CLKS / 2 - 1);
    localparam logic [BitW-1:0] DataLast  = BitW'(DATA_WIDTH - 1);
    localparam logic [BitW-1:0] StopLast  = BitW'(STOP_BITS - 1);
    localparam logic            HasParity = (PARITY != 0);
    localparam logic            ParOdd    = (PARITY == 2);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StStart    = 3'd1;
    localparam logic [2:0] StData     = 3'd2;
    localparam logic [2:0] StParity   = 3'd3;
    localparam logic [2:0] StStop     = 3'd4;
    localparam logic [2:0] StWaitHigh = 3'd5;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] tx_mem_q [FIFO_DEPTH];
    logic [AddrW:0]        tx_wptr_q, tx_rptr_q;
    logic                  tx_full, tx_empty, tx_push, tx_pop;
    logic [DATA_WIDTH-1:0] tx_head;

    assign tx_empty = (tx_wptr_q == tx_rptr_q);
    assign tx_full  = (tx_wptr_q[AddrW] != tx_rptr_q[AddrW]) &&
                      (tx_wptr_q[AddrW-1:0] == tx_rptr_q[AddrW-1:0]);
    assign txrdy    = ~tx_full;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign tx_push  = ~wen & (~tx_full | tx_pop);
    assign tx_head  = tx_mem_q[tx_rptr_q[AddrW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wptr_q[AddrW-1:0]] <= data_in;
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    logic [2:0]            tx_state_q, tx_state_d;
    logic [CntW-1:0]       tx_cnt_q, tx_cnt_d;
    logic [BitW-1:0]       tx_bit_q, tx_bit_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic                  tx_par_q, tx_par_d;
    logic                  tx_q, tx_d;
    logic                  tx_tick;

    assign tx_tick = (tx_cnt_q == CntLast);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_pop     = 1'b0;
        tx_cnt_d   = (tx_state_q == StIdle || tx_tick) ? '0 : tx_cnt_q + 1'b1;

        unique case (tx_state_q)
            StIdle: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_par_d   = (^tx_head) ^ ParOdd;
                    tx_state_d = StStart;
                end
            end
            StStart: begin
                if (tx_tick) begin
                    tx_bit_d   = '0;
                    tx_state_d = StData;
                end
            end
            StData: begin
                if (tx_tick) begin
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_bit_q == DataLast) begin
                        tx_bit_d   = '0;
                        tx_state_d = HasParity ? StParity : StStop;
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (tx_tick) begin
                    tx_bit_d   = '0;
                    tx_state_d = StStop;
                end
            end
            StStop: begin
                if (tx_tick) begin
                    if (tx_bit_q != StopLast) begin
                        tx_bit_d = tx_bit_q + 1'b1;
                    end else if (!tx_empty) begin
                        // Chain straight into the next frame without an idle bit.
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_head;
                        tx_par_d   = (^tx_head) ^ ParOdd;
                        tx_state_d = StStart;
                    end else begin
                        tx_state_d = StIdle;
                    end
                end
            end
            default: tx_state_d = StIdle;
        endcase

        case (tx_state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = tx_shift_d[0];
            StParity: tx_d = tx_par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= StIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
        end
    end

    assign tx = tx_q;

    // ------------------------------------------------------------------
    // RX synchroniser and FSM
    // ------------------------------------------------------------------
    logic                  rx_s1_q, rx_s2_q, rx_sync;
    logic [2:0]            rx_state_q, rx_state_d;
    logic [CntW-1:0]       rx_cnt_q, rx_cnt_d;
    logic [BitW-1:0]       rx_bit_q, rx_bit_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic                  rx_tick, rx_push, rx_pop, rx_full, rx_empty;
    logic                  par_set, frame_set, ovf_set;

    assign rx_sync = rx_s2_q;
    assign rx_tick = (rx_cnt_q == CntLast);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        par_set    = 1'b0;
        frame_set  = 1'b0;
        ovf_set    = 1'b0;

        unique case (rx_state_q)
            StIdle: begin
                rx_cnt_d = '0;
                if (!rx_sync) rx_state_d = StStart;
            end
            StStart: begin
                // Mid-bit recheck rejects glitches shorter than half a bit.
                if (rx_cnt_q == CntHalf) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync ? StIdle : StData;
                end
            end
            StData: begin
                if (rx_tick) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync, rx_shift_q[DATA_WIDTH-1:1]};
                    if (rx_bit_q == DataLast) begin
                        rx_state_d = HasParity ? StParity : StStop;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (rx_tick) begin
                    rx_cnt_d   = '0;
                    par_set    = rx_sync ^ (^rx_shift_q) ^ ParOdd;
                    rx_state_d = StStop;
                end
            end
            StStop: begin
                if (rx_tick) begin
                    rx_cnt_d = '0;
                    if (!rx_sync) begin
                        frame_set  = 1'b1;
                        rx_state_d = StWaitHigh;
                    end else begin
                        if (!rx_full || rx_pop) rx_push = 1'b1;
                        else                    ovf_set = 1'b1;
                        rx_state_d = StIdle;
                    end
                end
            end
            StWaitHigh: begin
                rx_cnt_d = '0;
                if (rx_sync) rx_state_d = StIdle;
            end
            default: rx_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_state_q <= StIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rx_mem_q [FIFO_DEPTH];
    logic [AddrW:0]        rx_wptr_q, rx_rptr_q;

    assign rx_empty = (rx_wptr_q == rx_rptr_q);
    assign rx_full  = (rx_wptr_q[AddrW] != rx_rptr_q[AddrW]) &&
                      (rx_wptr_q[AddrW-1:0] == rx_rptr_q[AddrW-1:0]);
    assign rxrdy    = ~rx_empty;
    assign rx_pop   = ~oen & rxrdy;
    assign data_out = rxrdy ? rx_mem_q[rx_rptr_q[AddrW-1:0]] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
        end else begin
            if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem_q[rx_wptr_q[AddrW-1:0]] <= rx_shift_q;
    end

    // ------------------------------------------------------------------
    // Sticky error flags; a new event wins over a coincident clear.
    // ------------------------------------------------------------------
    logic parity_err_q, framing_err_q, overflow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            parity_err_q  <= (parity_err_q  & ~err_clr) | par_set;
            framing_err_q <= (framing_err_q & ~err_clr) | frame_set;
            overflow_q    <= (overflow_q    & ~err_clr) | ovf_set;
        end
    end

    assign parity_err  = parity_err_q;
    assign framing_err = framing_err_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_uart_core_fifo.sv
// Self-checking bench for uart_core_fifo (8 data bits, 16 clks/bit, even parity, 1 stop, depth 4).
module tb_uart_core_fifo;

    localparam int BC = 16;
    localparam int FL = 11 * BC;

    logic       clk = 1'b0;
    logic       rst, wen, oen, err_clr, rx_drv, loop_en;
    logic [7:0] data_in, data_out;
    logic       txrdy, rxrdy, tx, parity_err, framing_err, overflow;
    logic       rx_line;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] wr_bytes [8];
    logic [7:0] sent_q [$];

    assign rx_line = loop_en ? tx : rx_drv;
    always #5 clk = ~clk;

    uart_core_fifo #(
        .DATA_WIDTH(8),
        .BIT_CLKS  (16),
        .PARITY    (1),
        .STOP_BITS (1),
        .FIFO_DEPTH(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wen        (wen),
        .data_in    (data_in),
        .txrdy      (txrdy),
        .oen        (oen),
        .data_out   (data_out),
        .rxrdy      (rxrdy),
        .tx         (tx),
        .rx         (rx_line),
        .err_clr    (err_clr),
        .parity_err (parity_err),
        .framing_err(framing_err),
        .overflow   (overflow)
    );

    // Bit k of a serial frame: start, 8 data LSB first, even parity, stop.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == 9) return ^b;
        return 1'b1;
    endfunction

    // Writes wr_bytes[0..nw-1] on consecutive cycles, checks tx and txrdy every cycle.
    task automatic run_tx_stream(input int nw, input string name);
        int   cnt = 0;
        int   npops = 0;
        int   next_pop = 1;
        int   f;
        logic pop_now, push_now, exp_tx, exp_rdy;
        sent_q.delete();
        for (int t = 0; t < nw * FL + 12; t++) begin
            @(negedge clk);
            f       = (t - 2) / FL;
            exp_tx  = (t >= 2 && f < npops) ? frame_bit(sent_q[f], ((t - 2) % FL) / BC) : 1'b1;
            exp_rdy = (cnt < 4);
            vectors++;
            if (tx !== exp_tx) begin
                miscompares++;
                $display("FAIL %s_tx cycle=%0d got=%b want=%b", name, t, tx, exp_tx);
            end
            vectors++;
            if (txrdy !== exp_rdy) begin
                miscompares++;
                $display("FAIL %s_txrdy cycle=%0d got=%b want=%b", name, t, txrdy, exp_rdy);
            end
            pop_now  = (t == next_pop) && (cnt > 0);
            push_now = (t < nw) && (cnt < 4 || pop_now);
            wen      = !(t < nw);
            data_in  = (t < nw) ? wr_bytes[t] : 8'h00;
            if (pop_now) begin
                npops++;
                next_pop += FL;
                cnt--;
            end
            if (push_now) begin
                sent_q.push_back(wr_bytes[t]);
                cnt++;
            end
        end
        wen = 1'b1;
    endtask

    task automatic send_rx_frame(input logic [7:0] b, input logic par, input logic stop);
        logic [10:0] bits;
        bits = {stop, par, b, 1'b0};
        for (int k = 0; k < 11; k++) begin
            rx_drv = bits[k];
            repeat (BC) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    task automatic pop_one();
        oen = 1'b0;
        @(negedge clk);
        oen = 1'b1;
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; wen = 1'b1; oen = 1'b1; err_clr = 1'b0;
        rx_drv = 1'b1; loop_en = 1'b0; data_in = 8'h00;
        repeat (3) @(negedge clk);
        vectors++;
        if ({tx, txrdy, rxrdy} !== 3'b110) begin
            miscompares++;
            $display("FAIL reset_status got=%b want=110", {tx, txrdy, rxrdy});
        end
        vectors++;
        if (data_out !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_data_out got=%h want=00", data_out);
        end
        vectors++;
        if ({parity_err, framing_err, overflow} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags got=%b want=000", {parity_err, framing_err, overflow});
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if (tx !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_idle_tx got=%b want=1", tx);
        end
    endtask

    task automatic test_single_write();
        wr_bytes[0] = 8'h8F;
        run_tx_stream(1, "single8f");
        wr_bytes[0] = 8'($urandom);
        run_tx_stream(1, "single_rand");
    endtask

    task automatic loopback_round(input string name);
        loop_en = 1'b1;
        run_tx_stream(4, name);
        repeat (8) @(negedge clk);
        loop_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (rxrdy !== 1'b1 || data_out !== sent_q[i]) begin
                miscompares++;
                $display("FAIL %s_read%0d got=%b/%h want=1/%h", name, i, rxrdy, data_out, sent_q[i]);
            end
            pop_one();
        end
        vectors++;
        if (rxrdy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_empty got=%b want=0", name, rxrdy);
        end
        vectors++;
        if ({parity_err, framing_err, overflow} !== 3'b000) begin
            miscompares++;
            $display("FAIL %s_flags got=%b want=000", name, {parity_err, framing_err, overflow});
        end
    endtask

    task automatic test_loopback();
        wr_bytes[0] = 8'hF3; wr_bytes[1] = 8'h00; wr_bytes[2] = 8'hA5; wr_bytes[3] = 8'h5A;
        loopback_round("loop_fixed");
        for (int i = 0; i < 4; i++) wr_bytes[i] = 8'($urandom);
        loopback_round("loop_rand");
    endtask

    task automatic test_tx_full();
        for (int i = 0; i < 6; i++) wr_bytes[i] = 8'($urandom);
        run_tx_stream(6, "txfull");
    endtask

    task automatic test_parity_err();
        logic [7:0] b;
        b = 8'($urandom);
        send_rx_frame(b, ^b, 1'b1);
        repeat (4) @(negedge clk);
        vectors++;
        if (rxrdy !== 1'b1 || data_out !== b || parity_err !== 1'b0) begin
            miscompares++;
            $display("FAIL par_good got=%b/%h/%b want=1/%h/0", rxrdy, data_out, parity_err, b);
        end
        pop_one();
        send_rx_frame(8'h01, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        vectors++;
        if (rxrdy !== 1'b1 || data_out !== 8'h01) begin
            miscompares++;
            $display("FAIL par_bad_data got=%b/%h want=1/01", rxrdy, data_out);
        end
        vectors++;
        if (parity_err !== 1'b1) begin
            miscompares++;
            $display("FAIL par_bad_flag got=%b want=1", parity_err);
        end
        pop_one();
        clear_errors();
        vectors++;
        if (parity_err !== 1'b0 || rxrdy !== 1'b0) begin
            miscompares++;
            $display("FAIL par_clear got=%b/%b want=0/0", parity_err, rxrdy);
        end
    endtask

    task automatic test_framing();
        logic [7:0] b;
        b = 8'($urandom);
        send_rx_frame(b, ^b, 1'b0);
        rx_drv = 1'b0;
        repeat (40) @(negedge clk);
        vectors++;
        if (framing_err !== 1'b1 || rxrdy !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_bad got=%b/%b want=1/0", framing_err, rxrdy);
        end
        rx_drv = 1'b1;
        repeat (2 * BC) @(negedge clk);
        send_rx_frame(8'h3C, ^8'h3C, 1'b1);
        repeat (4) @(negedge clk);
        vectors++;
        if (rxrdy !== 1'b1 || data_out !== 8'h3C) begin
            miscompares++;
            $display("FAIL frame_recover got=%b/%h want=1/3c", rxrdy, data_out);
        end
        pop_one();
        vectors++;
        if (rxrdy !== 1'b0 || framing_err !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_after_pop got=%b/%b want=0/1", rxrdy, framing_err);
        end
        clear_errors();
        vectors++;
        if (framing_err !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_clear got=%b want=0", framing_err);
        end
    endtask

    task automatic test_overflow_reset();
        logic [7:0] v;
        int         lows = 0;
        for (int i = 0; i < 5; i++) begin
            v = 8'h10 + 8'(i);
            send_rx_frame(v, ^v, 1'b1);
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_flag got=%b want=1", overflow);
        end
        for (int i = 0; i < 4; i++) begin
            v = 8'h10 + 8'(i);
            vectors++;
            if (rxrdy !== 1'b1 || data_out !== v) begin
                miscompares++;
                $display("FAIL ovf_read%0d got=%b/%h want=1/%h", i, rxrdy, data_out, v);
            end
            pop_one();
        end
        vectors++;
        if (rxrdy !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_empty got=%b want=0", rxrdy);
        end
        // Leave one byte in the RX FIFO, then fill the TX FIFO and reset mid start bit.
        send_rx_frame(8'h77, ^8'h77, 1'b1);
        repeat (4) @(negedge clk);
        for (int t = 0; t < 6; t++) begin
            wen = 1'b0;
            data_in = 8'($urandom);
            @(negedge clk);
        end
        wen = 1'b1;
        vectors++;
        if ({tx, txrdy, rxrdy} !== 3'b001) begin
            miscompares++;
            $display("FAIL prereset got=%b want=001", {tx, txrdy, rxrdy});
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({tx, txrdy, rxrdy} !== 3'b110) begin
            miscompares++;
            $display("FAIL midreset got=%b want=110", {tx, txrdy, rxrdy});
        end
        vectors++;
        if ({overflow, data_out} !== 9'h000) begin
            miscompares++;
            $display("FAIL midreset_clear got=%b/%h want=0/00", overflow, data_out);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 2 * FL; t++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        vectors++;
        if (lows !== 0) begin
            miscompares++;
            $display("FAIL postreset_idle low_cycles=%0d want=0", lows);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_write();
        test_loopback();
        test_tx_full();
        test_parity_err();
        test_framing();
        test_overflow_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_core_fifo.md
# uart_core_fifo

Synthesizable, parametrised UART core that replaces the fixed-timing CoreUART behavioural stub in the echo datapath. It keeps the same parallel handshake (active-low `wen`/`oen` strobes, `txrdy`/`rxrdy` status) and adds real serial TX/RX, configurable frame format, TX/RX FIFOs and sticky error reporting. It sits between the echo controller and the board UART pins.

## Interface
- `DATA_WIDTH`, 8: data bits per frame, 5..8.
- `BIT_CLKS`, 16: clk cycles per serial bit, even, >= 4.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: entries per direction; power of two, >= 2.

Ports:
- `clk` input, 1 bit: sole clock; all logic is on its rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `wen` input, 1 bit: active-low write strobe. Pushes `data_in` on every cycle it is low and `txrdy` is 1.
- `data_in` input, `DATA_WIDTH` bits: TX byte.
- `txrdy` output, 1 bit: TX FIFO not full.
- `oen` input, 1 bit: active-low read strobe. Pops the RX FIFO on every cycle it is low and `rxrdy` is 1.
- `data_out` output, `DATA_WIDTH` bits: RX FIFO head. Valid while `rxrdy` is 1.
- `rxrdy` output, 1 bit: RX FIFO not empty.
- `tx` output, 1 bit: serial out, idle high.
- `rx` input, 1 bit: serial in, asynchronous.
- `err_clr` input, 1 bit: clears all sticky error flags.
- `parity_err`, `framing_err`, `overflow` outputs, 1 bit each: sticky error flags.

## Operation
- Reset values: `tx`=1, `txrdy`=1, `rxrdy`=0, `data_out`=0, all error flags 0, both FIFOs empty, both FSMs IDLE. Asserting `rst` mid-frame aborts the frame immediately and drives `tx` high.
- Frame format: start bit (0), data LSB first, optional parity bit, then `STOP_BITS` stop bits (1).
  - Frame length is (1 + `DATA_WIDTH` + (`PARITY`!=0) + `STOP_BITS`) × `BIT_CLKS` clocks.
  - Even parity: XOR of the data bits. Odd parity: its inverse.
- TX FSM states: IDLE → START → DATA → PARITY (skipped if `PARITY`=0) → STOP → IDLE.
  - In IDLE with the FIFO non-empty, it pops the head into the shifter. `tx` goes low on the next cycle.
  - From STOP, if the FIFO is non-empty, it goes directly to START with no idle gap.
- TX write when full: the write is dropped silently. No flag is set.
- RX input: `rx` passes through a 2-flop synchroniser, giving 2 cycles of latency.
- RX FSM states: IDLE → START → DATA → PARITY → STOP → IDLE, plus WAIT_HIGH.
  - In IDLE, a synchronised low starts a counter. At `BIT_CLKS`/2 the line is re-sampled. If it is high (glitch), return to IDLE.
  - After the start check, each subsequent bit is sampled every `BIT_CLKS` clocks. Only the first stop bit is checked.
- RX completion rules:
  - Stop bit sampled 0: set `framing_err`, discard the byte, go to WAIT_HIGH. WAIT_HIGH returns to IDLE once the synchronised line is 1.
  - Parity mismatch: set `parity_err`. The byte is still pushed.
  - Good stop bit with the RX FIFO full (after any same-cycle pop): discard the byte and set `overflow`.
- Simultaneous events:
  - Push and pop on the same cycle succeed on either FIFO, including when it is full or empty as appropriate. The count is unchanged.
  - If `err_clr` coincides with a new error event, the set wins.
- Pointer widths are log2(`FIFO_DEPTH`)+1 bits with a wrap bit. Full means the indices are equal and the wrap bits differ.

## Timing
- `txrdy` falls on the cycle after the push that fills the FIFO. It rises the cycle after the pop that frees an entry.
- Pushing into an empty TX FIFO with TX idle: the pop happens on cycle +1 and `tx` goes low on cycle +2.
- `rxrdy` and `data_out` update on the cycle after the stop-bit sample.
- After a pop, the next head appears on `data_out` the following cycle. `rxrdy` falls the same cycle if the FIFO is emptied.
- The start-edge-to-sample error is at most 3 clocks (2 for the synchroniser, 1 for detection), well within ±`BIT_CLKS`/2.

## Test plan
Configuration for all tests: `DATA_WIDTH`=8, `BIT_CLKS`=16, `PARITY`=1, `STOP_BITS`=1, `FIFO_DEPTH`=4.

- Single write of 0x8F.
  - `tx` shows 0 for 16 clocks, then 1,1,1,1,0,0,0,1, then parity 1, then stop 1.
  - Total is 176 clocks, with the low edge 2 cycles after the write.
- Loopback (`tx`→`rx`), writing 0xF3, 0x00, 0xA5, 0x5A.
  - Frames are back-to-back with no gaps.
  - Reads return the same bytes in order, with all error flags 0.
- Write 6 bytes on consecutive cycles from idle.
  - `txrdy`=0 after the 5th write, and the 6th byte is dropped.
  - Exactly 5 frames are transmitted.
- Drive an `rx` frame carrying 0x01 with parity bit 0.
  - 0x01 is read and `parity_err`=1.
  - A one-cycle `err_clr` pulse returns `parity_err` to 0.
- Drive an `rx` frame with the stop bit 0, then hold the line low for 40 clocks, then send a valid 0x3C frame.
  - `framing_err`=1, with no push for the bad frame.
  - 0x3C is received.
- Send 5 `rx` frames 0x10..0x14 with no reads.
  - `overflow`=1.
  - Reads return 0x10..0x13, after which `rxrdy`=0.
  - Then assert `rst` mid-TX-frame: `tx`=1, FIFOs are empty and `txrdy`=1 immediately.
